kbd_event_sched: RTL and testbench
==================================

// Module: kbd_event_sched
// PURPOSE
//  Schedules key make/break events from two requesters into the PC-8001 keyboard matrix.
//  Requester 0 is the USB keyboard decoder; requester 1 is the autotype/paste source.
//  Owns the 16x8 active-low matrix registers and arbitrates between the two requesters
//  round-robin. Holds each change stable for a minimum time so the CPU key scan sees it.
//  Serves the kbd_adr/kbd_data read port used by the PC-8001 core.
// PARAMETERS
//  ROWS      10     number of implemented matrix rows; row >= ROWS is an illegal event
//  HOLD_W    16     width of hold counter
//  HOLD_CYC  12000  cycles the matrix stays frozen after an applied event (1 ms @ 12 MHz); 0 = no hold
// PORTS
//  clk         in   1  single clock, all logic on posedge
//  reset       in   1  synchronous, active-high reset
//  req0_valid  in   1  requester 0 has an event
//  req0_ready  out  1  requester 0 event accepted this cycle when valid&ready
//  req0_row    in   4  matrix row of event
//  req0_col    in   3  matrix column (bit) of event
//  req0_make   in   1  1 = press (bit cleared to 0), 0 = release (bit set to 1)
//  req1_valid / req1_ready / req1_row / req1_col / req1_make   same as requester 0
//  clear_all   in   1  release every key (USB disconnect); level, sampled each cycle
//  kbd_adr     in   4  CPU matrix row select
//  kbd_data    out  8  matrix row contents, registered, active low
//  busy        out  1  1 while in APPLY or HOLD
//  err_drop    out  1  one-cycle pulse: accepted event had row >= ROWS and was discarded
// BEHAVIOUR
//  Reset: all matrix rows = 8'hFF; kbd_data = 8'hFF; state IDLE; hold counter 0;
//   busy = 0; err_drop = 0; ready outputs 0 while reset is high; last_grant = 1, so req0 wins first.
//  Read port: kbd_data <= matrix[kbd_adr] every cycle; kbd_adr >= ROWS reads 8'hFF.
//  Arbitration, IDLE only: grant0 = req0_valid & (~req1_valid | last_grant==1).
//   grant1 = req1_valid & ~grant0.
//   reqN_ready = (state==IDLE) & grantN & ~clear_all & ~reset, combinational.
//   At most one ready is high in any cycle. last_grant updates only on a handshake.
//  States:
//   IDLE  -> APPLY on handshake. Latch row/col/make.
//   APPLY -> write matrix[row][col] = ~make.
//            row < ROWS: load hold counter with HOLD_CYC; go to HOLD, or IDLE if HOLD_CYC==0.
//            row >= ROWS: no write, pulse err_drop, go to IDLE.
//   HOLD  -> decrement counter; go to IDLE on the cycle the counter reaches 1.
//            HOLD lasts exactly HOLD_CYC cycles.
//  Latency: handshake at edge T; matrix updated at T+1; visible on kbd_data at T+2.
//  Throughput: one event per HOLD_CYC+2 cycles (HOLD_CYC=0: one event per 2 cycles).
//  Duplicate events (press of a pressed key, release of a released key) are written as normal
//   and consume a full hold.
//  clear_all:
//   - Highest priority. At the next edge all rows = 8'hFF, state = IDLE, counter = 0, no err_drop.
//   - An event latched in APPLY is discarded.
//   - Ready is low while clear_all is high, so no handshake happens that cycle.
//  Reset mid-operation: same as the reset values above; in-flight event lost; last_grant = 1.
//  Requesters must hold valid and payload stable until ready. The block does not rely on this:
//   the payload is sampled only on the handshake edge.
// TESTING (bench uses HOLD_CYC=4)
//  1 Reset, sweep kbd_adr 0..15 -> kbd_data == 8'hFF for every row; both ready low during reset.
//  2 req0 row2 col3 make=1 -> handshake at T; kbd_adr=2 reads 8'hF7 from T+2;
//    busy high T+1..T+5; next ready at T+6.
//  3 req0 and req1 both valid continuously with distinct events -> grants alternate 0,1,0,1,
//    starting with 0; no event lost or repeated.
//  4 req1 row12 col0 make=1 -> err_drop pulses once at T+1; matrix unchanged; ready high again at T+2.
//  5 press row0 col0 and row5 col7, then clear_all for 1 cycle during HOLD -> all rows 8'hFF,
//    busy 0 next cycle; pending req0 accepted after clear_all drops.
//  6 reset asserted in APPLY -> matrix all 8'hFF, event not applied, req0 wins the first grant after reset.

Source files
------------

// File: rtl/kbd_event_sched.sv
// kbd_event_sched
//   Applies key make/break events from two requesters to the PC-8001 keyboard
//   matrix. Requester 0 is the USB keyboard decoder and requester 1 is the
//   autotype/paste source. The two are served round-robin. After each applied
//   event the matrix is frozen for HOLD_CYC cycles so the CPU key scan is sure
//   to see the change.
//
// Ports
//   clk, reset                     single clock; synchronous active-high reset
//   reqN_valid/ready/row/col/make  event handshake (N = 0, 1); make=1 presses the key
//   clear_all                      releases every key; level-sensitive, highest priority
//   kbd_adr, kbd_data              CPU row select and registered row contents (active low)
//   busy                           high while an event is being applied or held
//   err_drop                       one-cycle pulse when an event with an illegal row is discarded
//
// state | meaning
// IDLE  | waiting for a handshake from either requester
// APPLY | latched event is written to the matrix (or dropped if its row is illegal)
// HOLD  | matrix frozen; down-counter runs until it reaches 1

module kbd_event_sched #(
    parameter int ROWS     = 10,
    parameter int HOLD_W   = 16,
    parameter int HOLD_CYC = 12000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [3:0] req0_row,
    input  logic [2:0] req0_col,
    input  logic       req0_make,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [3:0] req1_row,
    input  logic [2:0] req1_col,
    input  logic       req1_make,
    input  logic       clear_all,
    input  logic [3:0] kbd_adr,
    output logic [7:0] kbd_data,
    output logic       busy,
    output logic       err_drop
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_APPLY,
        S_HOLD
    } state_t;

    localparam logic [4:0]        ROWS_L  = 5'(ROWS);
    localparam logic [HOLD_W-1:0] HOLD_LD = HOLD_W'(HOLD_CYC);

    state_t            state;
    logic [HOLD_W-1:0] hold_cnt;
    logic              last_grant;   // 1 = requester 1 was served last
    logic [3:0]        lat_row;
    logic [2:0]        lat_col;
    logic              lat_make;
    logic              grant0;
    logic              grant1;
    logic              row_ok;
    logic [7:0]        rd_data;

    // Full 16-row array so any 4-bit address is a legal index; rows at or
    // above ROWS are never written and stay at 8'hFF.
    logic [7:0]        matrix [16];

    assign grant0     = req0_valid & (~req1_valid | last_grant);
    assign grant1     = req1_valid & ~grant0;
    assign req0_ready = (state == S_IDLE) & grant0 & ~clear_all & ~reset;
    assign req1_ready = (state == S_IDLE) & grant1 & ~clear_all & ~reset;
    assign row_ok     = ({1'b0, lat_row} < ROWS_L);

    always_comb begin
        rd_data = 8'hFF;
        if ({1'b0, kbd_adr} < ROWS_L) begin
            rd_data = matrix[kbd_adr];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < 16; r++) begin
                matrix[r] <= 8'hFF;
            end
            state      <= S_IDLE;
            hold_cnt   <= '0;
            last_grant <= 1'b1;
            busy       <= 1'b0;
            err_drop   <= 1'b0;
            kbd_data   <= 8'hFF;
            lat_row    <= '0;
            lat_col    <= '0;
            lat_make   <= 1'b0;
        end else begin
            kbd_data <= rd_data;
            err_drop <= 1'b0;
            if (clear_all) begin
                // Overrides everything, including an event sitting in APPLY.
                for (int r = 0; r < 16; r++) begin
                    matrix[r] <= 8'hFF;
                end
                state    <= S_IDLE;
                hold_cnt <= '0;
                busy     <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (req0_ready | req1_ready) begin
                            lat_row    <= req0_ready ? req0_row  : req1_row;
                            lat_col    <= req0_ready ? req0_col  : req1_col;
                            lat_make   <= req0_ready ? req0_make : req1_make;
                            last_grant <= req1_ready;
                            state      <= S_APPLY;
                            busy       <= 1'b1;
                        end
                    end
                    S_APPLY: begin
                        if (row_ok) begin
                            // Active-low matrix: a press clears the bit.
                            matrix[lat_row][lat_col] <= ~lat_make;
                            hold_cnt                 <= HOLD_LD;
                            if (HOLD_CYC == 0) begin
                                state <= S_IDLE;
                                busy  <= 1'b0;
                            end else begin
                                state <= S_HOLD;
                            end
                        end else begin
                            err_drop <= 1'b1;
                            state    <= S_IDLE;
                            busy     <= 1'b0;
                        end
                    end
                    S_HOLD: begin
                        hold_cnt <= hold_cnt - HOLD_W'(1);
                        if (hold_cnt == HOLD_W'(1)) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_kbd_event_sched.sv
// tb_kbd_event_sched
//   Directed bench for kbd_event_sched with HOLD_CYC = 4 and ROWS = 10.
//   Inputs are driven 1 ns after a rising edge (or on a falling edge) and
//   outputs are sampled on the falling edge.

module tb_kbd_event_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0_valid, req0_ready, req0_make;
    logic [3:0] req0_row;
    logic [2:0] req0_col;
    logic       req1_valid, req1_ready, req1_make;
    logic [3:0] req1_row;
    logic [2:0] req1_col;
    logic       clear_all;
    logic [3:0] kbd_adr;
    logic [7:0] kbd_data;
    logic       busy;
    logic       err_drop;

    int n_vec = 0;
    int n_err = 0;

    kbd_event_sched #(
        .ROWS     (10),
        .HOLD_W   (16),
        .HOLD_CYC (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_row   (req0_row),
        .req0_col   (req0_col),
        .req0_make  (req0_make),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_row   (req1_row),
        .req1_col   (req1_col),
        .req1_make  (req1_make),
        .clear_all  (clear_all),
        .kbd_adr    (kbd_adr),
        .kbd_data   (kbd_data),
        .busy       (busy),
        .err_drop   (err_drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic read_row(input logic [3:0] adr, input logic [7:0] exp, input string tag);
        @(negedge clk);
        kbd_adr = adr;
        @(posedge clk);
        @(negedge clk);
        check(tag, {24'd0, kbd_data}, {24'd0, exp});
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    // Presents one event and returns 1 ns after its handshake edge with valid dropped.
    task automatic send(input bit who, input logic [3:0] row, input logic [2:0] col,
                        input logic make);
        int n = 0;
        bit got = 1'b0;
        @(posedge clk);
        #1;
        if (!who) begin
            req0_valid = 1'b1; req0_row = row; req0_col = col; req0_make = make;
        end else begin
            req1_valid = 1'b1; req1_row = row; req1_col = col; req1_make = make;
        end
        while (!got && n < 50) begin
            @(negedge clk);
            got = who ? req1_ready : req0_ready;
            n++;
        end
        check("send_timeout", {31'd0, got}, 32'd1);
        @(posedge clk);
        #1;
        if (!who) req0_valid = 1'b0;
        else      req1_valid = 1'b0;
    endtask

    int order[$];
    int i0, i1, both_hi;
    bit h0, h1;

    initial begin
        reset = 1'b1;
        req0_valid = 1'b0; req0_row = '0; req0_col = '0; req0_make = 1'b0;
        req1_valid = 1'b0; req1_row = '0; req1_col = '0; req1_make = 1'b0;
        clear_all = 1'b0;
        kbd_adr = '0;

        // 1: reset state and full read sweep
        repeat (3) @(posedge clk);
        #1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        @(negedge clk);
        check("rst_ready0", {31'd0, req0_ready}, 32'd0);
        check("rst_ready1", {31'd0, req1_ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_err", {31'd0, err_drop}, 32'd0);
        check("rst_kbd", {24'd0, kbd_data}, 32'hFF);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        reset = 1'b0;
        for (int a = 0; a < 16; a++) begin
            read_row(4'(a), 8'hFF, "sweep");
        end

        // 2: single press, latency and hold timing; a queued release waits out the hold
        @(posedge clk);
        #1;
        req0_valid = 1'b1; req0_row = 4'd2; req0_col = 3'd3; req0_make = 1'b1;
        kbd_adr = 4'd2;
        @(negedge clk);
        check("t2_ready", {31'd0, req0_ready}, 32'd1);
        @(posedge clk);  // handshake edge T
        #1;
        req0_make = 1'b0;  // release of the same key stays pending
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("t2_busy", {31'd0, busy}, (k <= 4) ? 32'd1 : 32'd0);
            check("t2_kbd", {24'd0, kbd_data}, (k >= 2) ? 32'hF7 : 32'hFF);
            check("t2_ready_next", {31'd0, req0_ready}, (k == 5) ? 32'd1 : 32'd0);
            if (k < 5) @(posedge clk);
        end
        @(posedge clk);  // T+6: release accepted
        #1;
        req0_valid = 1'b0;
        wait_idle();
        read_row(4'd2, 8'hFF, "t2_release");

        // 3: both requesters valid, grants alternate starting with requester 0
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        i0 = 0; i1 = 0; both_hi = 0;
        req0_valid = 1'b1; req0_row = 4'd1; req0_col = 3'd0; req0_make = 1'b1;
        req1_valid = 1'b1; req1_row = 4'd3; req1_col = 3'd0; req1_make = 1'b1;
        for (int cyc = 0; cyc < 200 && (i0 < 3 || i1 < 3); cyc++) begin
            @(negedge clk);
            h0 = req0_ready;
            h1 = req1_ready;
            if (h0 && h1) both_hi++;
            if (h0) order.push_back(0);
            if (h1) order.push_back(1);
            @(posedge clk);
            #1;
            if (h0) begin
                i0++;
                if (i0 < 3) req0_col = 3'(i0);
                else        req0_valid = 1'b0;
            end
            if (h1) begin
                i1++;
                if (i1 < 3) req1_col = 3'(i1);
                else        req1_valid = 1'b0;
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("t3_grant_count", order.size(), 32'd6);
        check("t3_both_ready", both_hi, 32'd0);
        for (int k = 0; k < order.size(); k++) begin
            check("t3_grant_order", order[k], k % 2);
        end
        wait_idle();
        read_row(4'd1, 8'hF8, "t3_row1");
        read_row(4'd3, 8'hF8, "t3_row3");

        // 4: illegal row is dropped with a single err_drop pulse
        @(posedge clk);
        #1;
        req1_valid = 1'b1; req1_row = 4'd12; req1_col = 3'd0; req1_make = 1'b1;
        @(negedge clk);
        check("t4_ready", {31'd0, req1_ready}, 32'd1);
        @(posedge clk);  // T
        #1;
        req1_row = 4'd4; req1_col = 3'd1;
        @(negedge clk);
        check("t4_err_early", {31'd0, err_drop}, 32'd0);
        check("t4_ready_apply", {31'd0, req1_ready}, 32'd0);
        @(posedge clk);  // T+1
        @(negedge clk);
        check("t4_err_pulse", {31'd0, err_drop}, 32'd1);
        check("t4_busy", {31'd0, busy}, 32'd0);
        check("t4_ready_again", {31'd0, req1_ready}, 32'd1);
        @(posedge clk);  // T+2: legal event accepted
        #1;
        req1_valid = 1'b0;
        @(negedge clk);
        check("t4_err_end", {31'd0, err_drop}, 32'd0);
        wait_idle();
        read_row(4'd12, 8'hFF, "t4_row12");
        read_row(4'd4, 8'hFD, "t4_row4");
        read_row(4'd2, 8'hFF, "t4_row2");

        // 5: clear_all during HOLD, pending event accepted afterwards
        send(1'b0, 4'd0, 3'd0, 1'b1);
        wait_idle();
        read_row(4'd0, 8'hFE, "t5_row0_pressed");
        send(1'b0, 4'd5, 3'd7, 1'b1);
        @(posedge clk);  // APPLY -> HOLD
        #1;
        clear_all = 1'b1;
        req0_valid = 1'b1; req0_row = 4'd6; req0_col = 3'd2; req0_make = 1'b1;
        @(negedge clk);
        check("t5_ready_clr", {31'd0, req0_ready}, 32'd0);
        check("t5_busy_hold", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1;
        clear_all = 1'b0;
        @(negedge clk);
        check("t5_busy_clr", {31'd0, busy}, 32'd0);
        check("t5_err_clr", {31'd0, err_drop}, 32'd0);
        check("t5_ready_after", {31'd0, req0_ready}, 32'd1);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        wait_idle();
        read_row(4'd0, 8'hFF, "t5_row0");
        read_row(4'd5, 8'hFF, "t5_row5");
        read_row(4'd4, 8'hFF, "t5_row4");
        read_row(4'd6, 8'hFB, "t5_row6");
        // clear_all in IDLE blocks the handshake
        @(posedge clk);
        #1;
        clear_all = 1'b1;
        req1_valid = 1'b1; req1_row = 4'd3; req1_col = 3'd3; req1_make = 1'b1;
        @(negedge clk);
        check("t5_ready_idle_clr", {31'd0, req1_ready}, 32'd0);
        @(posedge clk);
        #1;
        clear_all = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        check("t5_no_handshake", {31'd0, busy}, 32'd0);

        // 6: reset while an event sits in APPLY
        send(1'b0, 4'd7, 3'd4, 1'b1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("t6_busy", {31'd0, busy}, 32'd0);
        read_row(4'd7, 8'hFF, "t6_row7");
        read_row(4'd6, 8'hFF, "t6_row6");
        @(posedge clk);
        #1;
        req0_valid = 1'b1; req0_row = 4'd8; req0_col = 3'd0; req0_make = 1'b1;
        req1_valid = 1'b1; req1_row = 4'd9; req1_col = 3'd0; req1_make = 1'b1;
        @(negedge clk);
        check("t6_grant0", {31'd0, req0_ready}, 32'd1);
        check("t6_grant1", {31'd0, req1_ready}, 32'd0);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_idle();
        read_row(4'd8, 8'hFE, "t6_row8");
        read_row(4'd9, 8'hFF, "t6_row9");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, limit 500000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
